rank_topk_sorter: RTL and testbench

Streaming top-K selector for the PageRank result stage. It accepts (node id, 16-bit rank) pairs over a valid/ready handshake and keeps a list of the K highest ranks, sorted in descending order. All ordering decisions go through one shared `comp16` instance, one comparison per cycle. The sequencing FSM time-multiplexes that comparator across the tail check and the insertion scan, and exposes the finished list through a combinational read port.

---
 rtl/rank_topk_sorter.sv | 215 +++++++++++++++++++++
 tb/tb_rank_topk_sorter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_topk_sorter.sv
// Streaming top-K selector: keeps the K highest (id, rank) pairs in descending
// rank order, using a single shared 16-bit comparator for every ordering decision.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a candidate; in_ready high unless clr
// CHKTAIL | list full: compare candidate against entry[K-1]
// SCAN    | walk entries from index 0 looking for the insert position
// INSERT  | shift tail down by one and write candidate at ins_pos
// DONE    | one-cycle done pulse after the final element of a batch

module comp16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        g
);
    // Strict unsigned greater-than.
    assign g = (a > b);
endmodule

module rank_topk_sorter #(
    parameter int K    = 8,
    parameter int ID_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ID_W-1:0]          in_id,
    input  logic [15:0]              in_rank,
    input  logic                     in_last,
    output logic                     done,
    output logic [$clog2(K+1)-1:0]   count,
    input  logic [$clog2(K)-1:0]     rd_idx,
    output logic [ID_W-1:0]          rd_id,
    output logic [15:0]              rd_rank,
    output logic                     rd_valid
);
    localparam int CW = $clog2(K+1);
    localparam int IW = $clog2(K);
    localparam logic [CW-1:0] K_C = CW'(K);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHKTAIL = 3'd1,
        SCAN    = 3'd2,
        INSERT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0] ent_id   [K];
    logic [15:0]     ent_rank [K];

    logic [ID_W-1:0] cand_id;
    logic [15:0]     cand_rank;
    logic            cand_last;
    logic [CW-1:0]   scan_i;
    logic [CW-1:0]   ins_pos;
    logic [CW-1:0]   count_q;

    logic            full;
    logic [IW-1:0]   scan_idx;
    logic [15:0]     cmp_b;
    logic            cand_gt;

    logic            take;
    logic            scan_rst;
    logic            scan_inc;
    logic            pos_ld;
    logic            do_ins;

    assign full     = (count_q == K_C);
    // scan_i can reach count (== K when full); the comparator result is unused then.
    assign scan_idx = (scan_i < K_C) ? scan_i[IW-1:0] : '0;
    assign cmp_b    = (state == CHKTAIL) ? ent_rank[K-1] : ent_rank[scan_idx];

    comp16 u_comp (
        .a (cand_rank),
        .b (cmp_b),
        .g (cand_gt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; clr forces IDLE and suppresses all actions.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        scan_rst  = 1'b0;
        scan_inc  = 1'b0;
        pos_ld    = 1'b0;
        do_ins    = 1'b0;
        in_ready  = 1'b0;
        done      = (state == DONE);
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        take      = 1'b1;
                        scan_rst  = 1'b1;
                        state_nxt = full ? CHKTAIL : SCAN;
                    end
                end
                CHKTAIL: begin
                    if (cand_gt) begin
                        scan_rst  = 1'b1;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = cand_last ? DONE : IDLE;
                    end
                end
                SCAN: begin
                    if (scan_i == count_q) begin
                        pos_ld    = 1'b1;
                        state_nxt = INSERT;
                    end else if (cand_gt) begin
                        pos_ld    = 1'b1;
                        state_nxt = INSERT;
                    end else begin
                        scan_inc  = 1'b1;
                    end
                end
                INSERT: begin
                    do_ins    = 1'b1;
                    state_nxt = cand_last ? DONE : IDLE;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath: candidate latch, scan index, insert position, list storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_id   <= '0;
            cand_rank <= '0;
            cand_last <= 1'b0;
            scan_i    <= '0;
            ins_pos   <= '0;
            count_q   <= '0;
            for (int j = 0; j < K; j++) begin
                ent_id[j]   <= '0;
                ent_rank[j] <= '0;
            end
        end else if (clr) begin
            cand_id   <= '0;
            cand_rank <= '0;
            cand_last <= 1'b0;
            scan_i    <= '0;
            ins_pos   <= '0;
            count_q   <= '0;
        end else begin
            if (take) begin
                cand_id   <= in_id;
                cand_rank <= in_rank;
                cand_last <= in_last;
            end
            if (scan_rst) begin
                scan_i <= '0;
            end else if (scan_inc) begin
                scan_i <= scan_i + 1'b1;
            end
            if (pos_ld) begin
                ins_pos <= scan_i;
            end
            if (do_ins) begin
                // Whole shift happens on one edge; entry[K-1] falls off when full.
                if (ins_pos == '0) begin
                    ent_id[0]   <= cand_id;
                    ent_rank[0] <= cand_rank;
                end
                for (int j = 1; j < K; j++) begin
                    if (CW'(j) == ins_pos) begin
                        ent_id[j]   <= cand_id;
                        ent_rank[j] <= cand_rank;
                    end else if (CW'(j) > ins_pos) begin
                        ent_id[j]   <= ent_id[j-1];
                        ent_rank[j] <= ent_rank[j-1];
                    end
                end
                if (!full) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    // Combinational read port; rd_valid masks stale storage beyond count.
    always_comb begin
        rd_id    = ent_id[rd_idx];
        rd_rank  = ent_rank[rd_idx];
        rd_valid = (CW'(rd_idx) < count_q);
    end

    assign count = count_q;

endmodule

// File: tb/tb_rank_topk_sorter.sv
// Directed bench for rank_topk_sorter (K=8, ID_W=8): table of sends with
// expected busy-cycle counts and done pulses, list read-back after each phase,
// plus hand sequences for clr/reset mid-operation and a back-to-back stream.

module tb_rank_topk_sorter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_id;
    logic [15:0] in_rank;
    logic        in_last;
    logic        done;
    logic [3:0]  count;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_id;
    logic [15:0] rd_rank;
    logic        rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    rank_topk_sorter #(.K(8), .ID_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_id    (in_id),
        .in_rank  (in_rank),
        .in_last  (in_last),
        .done     (done),
        .count    (count),
        .rd_idx   (rd_idx),
        .rd_id    (rd_id),
        .rd_rank  (rd_rank),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          clr_first;
        logic [7:0]  id;
        logic [15:0] rank;
        bit          last;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit c, input int id, input int rk, input bit lst,
                       input int busy, input int dn);
        vec_t v;
        v.clr_first = c;
        v.id        = 8'(id);
        v.rank      = 16'(rk);
        v.last      = lst;
        v.exp_busy  = busy;
        v.exp_done  = dn;
        vt.push_back(v);
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the block idle again.
    task automatic send(input logic [7:0] id, input logic [15:0] rk, input bit lst,
                        output int busy, output int dones);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        in_id    = id;
        in_rank  = rk;
        in_last  = lst;
        @(negedge clk);
        in_valid = 1'b0;
        in_id    = 8'($urandom);
        in_rank  = 16'($urandom);
        in_last  = 1'($urandom);
        busy  = 0;
        dones = 0;
        while (!in_ready && busy < 50) begin
            if (done) dones++;
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        #1;
        check("ready_during_clr", int'(in_ready), 0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        int busy, dones;
        for (int k = lo; k <= hi; k++) begin
            if (vt[k].clr_first) do_clr();
            send(vt[k].id, vt[k].rank, vt[k].last, busy, dones);
            check($sformatf("v%0d_busy", k), busy, vt[k].exp_busy);
            check($sformatf("v%0d_done", k), dones, vt[k].exp_done);
        end
    endtask

    task automatic check_list(input string nm, input int n, input int ids[8], input int rks[8]);
        check({nm, "_count"}, int'(count), n);
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            check($sformatf("%s_valid%0d", nm, k), int'(rd_valid), (k < n) ? 1 : 0);
            if (k < n) begin
                check($sformatf("%s_id%0d", nm, k), int'(rd_id), ids[k]);
                check($sformatf("%s_rank%0d", nm, k), int'(rd_rank), rks[k]);
            end
        end
        rd_idx = 3'd0;
        @(negedge clk);
    endtask

    logic [15:0] s_rank [20];
    int          ref_id [8];
    int          ref_rk [8];
    bit          used   [20];

    initial begin
        int busy, dones, idx, guard, best;

        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_id    = '0;
        in_rank  = '0;
        in_last  = 1'b0;
        rd_idx   = 3'd0;

        // Basic ordering.
        add(0, 1, 100, 0, 2, 0);
        add(0, 2, 300, 0, 2, 0);
        add(0, 3, 200, 1, 4, 1);
        // Full list: fill 10..80, drop 5, insert 45.
        for (int k = 1; k <= 8; k++) add(k == 1, k, k * 10, 0, 2, 0);
        add(0, 20, 5, 0, 1, 0);
        add(0, 9, 45, 1, 8, 1);
        // Ties.
        add(1, 7, 500, 0, 2, 0);
        add(0, 9, 500, 0, 3, 0);
        for (int k = 0; k < 6; k++) add(0, 10 + k, 600 + k * 100, 0, 2, 0);
        add(0, 30, 500, 1, 2, 1);
        // Byte-boundary ranks.
        add(1, 1, 16'h00FF, 0, 2, 0);
        add(0, 2, 16'h0100, 0, 2, 0);
        add(0, 3, 16'h0000, 0, 4, 0);
        add(0, 4, 16'hFFFF, 1, 3, 1);

        #1;
        check("rst_ready", int'(in_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_rank", int'(rd_rank), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(in_ready), 1);

        run_vecs(0, 2);
        check_list("basic", 3, '{2, 3, 1, 0, 0, 0, 0, 0}, '{300, 200, 100, 0, 0, 0, 0, 0});

        run_vecs(3, 11);
        check_list("full_drop", 8, '{8, 7, 6, 5, 4, 3, 2, 1}, '{80, 70, 60, 50, 40, 30, 20, 10});
        run_vecs(12, 12);
        check_list("full_ins", 8, '{8, 7, 6, 5, 9, 4, 3, 2}, '{80, 70, 60, 50, 45, 40, 30, 20});

        run_vecs(13, 21);
        check_list("ties", 8, '{15, 14, 13, 12, 11, 10, 7, 9},
                   '{1100, 1000, 900, 800, 700, 600, 500, 500});

        run_vecs(22, 25);
        check_list("bytes", 4, '{4, 2, 1, 3, 0, 0, 0, 0},
                   '{16'hFFFF, 16'h0100, 16'h00FF, 16'h0000, 0, 0, 0, 0});

        // clr while scanning: candidate discarded, no done.
        in_valid = 1'b1;
        in_id    = 8'd50;
        in_rank  = 16'd1;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("scan_busy", int'(in_ready), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_count", int'(count), 0);
        check("clr_ready", int'(in_ready), 1);
        check("clr_rd_valid", int'(rd_valid), 0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("clr_no_done", dones, 0);

        // clr beats a same-cycle transfer.
        clr      = 1'b1;
        in_valid = 1'b1;
        in_id    = 8'd51;
        in_rank  = 16'h1234;
        in_last  = 1'b0;
        #1;
        check("clr_xfer_ready", int'(in_ready), 0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("clr_xfer_count", int'(count), 0);

        send(8'd60, 16'h0200, 1'b0, busy, dones);
        check("after_clr_busy", busy, 2);
        check_list("after_clr", 1, '{60, 0, 0, 0, 0, 0, 0, 0}, '{16'h0200, 0, 0, 0, 0, 0, 0, 0});

        // Asynchronous reset while in INSERT (accept, SCAN i=0, SCAN i=1, INSERT).
        in_valid = 1'b1;
        in_id    = 8'd61;
        in_rank  = 16'h0010;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_insert_count", int'(count), 1);
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_ready", int'(in_ready), 1);
        check("arst_done", int'(done), 0);
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_rank", int'(rd_rank), 0);
        check("arst_rd_id", int'(rd_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_count", int'(count), 0);

        // Back-to-back stream with in_valid held high.
        for (int k = 0; k < 20; k++) s_rank[k] = 16'($urandom_range(0, 60));
        idx   = 0;
        guard = 0;
        dones = 0;
        in_valid = 1'b1;
        while (idx < 20 && guard < 2000) begin
            if (in_ready) begin
                in_id   = 8'(idx + 1);
                in_rank = s_rank[idx];
                in_last = (idx == 19);
                idx++;
            end else begin
                in_id   = 8'($urandom);
                in_rank = 16'($urandom);
                in_last = 1'($urandom);
            end
            @(negedge clk);
            if (done) dones++;
            guard++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("stream_accepted", idx, 20);
        check("stream_done", dones, 1);
        check("stream_ready", int'(in_ready), 1);

        for (int k = 0; k < 20; k++) used[k] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            best = -1;
            for (int j = 0; j < 20; j++) begin
                if (!used[j] && (best < 0 || s_rank[j] > s_rank[best])) best = j;
            end
            used[best] = 1'b1;
            ref_id[k]  = best + 1;
            ref_rk[k]  = int'(s_rank[best]);
        end
        check_list("stream", 8, ref_id, ref_rk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
